// File: rtl/custom_ip_regif_pkg.sv
// Shared constants and types for the custom accelerator register front end.
package custom_ip_regif_pkg;

    localparam int unsigned CH_BASE           = 32'h00;
    localparam int unsigned STATUS_OFF        = 32'h40;
    localparam int unsigned STATUS_STICKY_LSB = 0;
    localparam int unsigned STATUS_BUSY_LSB   = 16;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/custom_ip_regif.sv
// Host-side register front end: turns single-outstanding bus requests into
// per-channel write pulses toward the IP and shadows the IP's read-back data.
module custom_ip_regif
    import custom_ip_regif_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_i,
    output logic                     gnt_o,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic                     we_i,
    input  logic [DATA_W/8-1:0]      be_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic                     rvalid_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     err_o,
    output logic [NUM_CH*DATA_W-1:0] reg2ip_data_o,
    output logic [NUM_CH-1:0]        reg2ip_en_o,
    input  logic [NUM_CH-1:0]        done_i,
    input  logic [NUM_CH*DATA_W-1:0] ip2reg_data_i,
    input  logic [NUM_CH-1:0]        ip2reg_en_i
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e                         state_q, state_d;
    logic [CH_W-1:0]                ch_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [NUM_CH-1:0][DATA_W-1:0]  data_q;
    logic [NUM_CH-1:0][DATA_W-1:0]  rb_q;
    logic [NUM_CH-1:0]              sticky_q;
    logic [NUM_CH-1:0]              busy;
    logic [DATA_W-1:0]              rdata_q;
    logic                           err_q;
    logic [DATA_W-1:0]              status_val;

    logic [ADDR_W-1:0] ch_off;
    logic [CH_W-1:0]   ch_idx;
    logic              is_ch, is_status;
    logic              accept, wr_ch, wr_status;
    logic              done_hit, timeout_hit;

    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v,
                                                     input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    // Addresses below CH_BASE wrap to a huge offset and fall out of the channel window.
    assign ch_off    = addr_i - ADDR_W'(CH_BASE);
    assign is_ch     = (addr_i[1:0] == 2'b00) && (ch_off < ADDR_W'(NUM_CH * 4));
    assign ch_idx    = CH_W'(ch_off >> 2);
    assign is_status = (addr_i == ADDR_W'(STATUS_OFF));

    assign accept    = (state_q == IDLE) && req_i;
    assign wr_ch     = accept && we_i && is_ch;
    assign wr_status = accept && we_i && is_status;

    assign done_hit    = (state_q == WAIT) && done_i[ch_q];
    assign timeout_hit = (state_q == WAIT) && !done_i[ch_q] && (cnt_q <= CNT_W'(1));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        busy       = '0;
        status_val = '0;
        if (state_q == PULSE || state_q == WAIT) busy[ch_q] = 1'b1;
        status_val[STATUS_STICKY_LSB +: NUM_CH] = sticky_q;
        status_val[STATUS_BUSY_LSB   +: NUM_CH] = busy;
    end

    always_comb begin
        state_d     = state_q;
        gnt_o       = 1'b0;
        reg2ip_en_o = '0;
        unique case (state_q)
            IDLE: begin
                gnt_o = req_i;
                if (req_i) state_d = (we_i && is_ch) ? PULSE : RESP;
            end
            PULSE: begin
                reg2ip_en_o[ch_q] = 1'b1;
                state_d           = WAIT;
            end
            WAIT: begin
                if (done_hit || timeout_hit) state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all sequential state below is updated with non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (wr_ch) ch_q <= ch_idx;
            if (state_q == PULSE) begin
                cnt_q <= CNT_W'(TIMEOUT);
            end else if (state_q == WAIT && !done_i[ch_q] && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // NOTE: the shadow arrays are reset because the host may read them before any capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q   <= '0;
            rb_q     <= '0;
            sticky_q <= '0;
        end else begin
            // Merging at grant time lets the PULSE cycle already drive the merged value.
            if (wr_ch) data_q[ch_idx] <= byte_merge(data_q[ch_idx], wdata_i, be_i);
            for (int k = 0; k < NUM_CH; k++) begin
                if (ip2reg_en_i[k]) rb_q[k] <= ip2reg_data_i[k*DATA_W +: DATA_W];
                if (timeout_hit && ch_q == CH_W'(k)) begin
                    sticky_q[k] <= 1'b1;
                end else if (wr_status && wdata_i[STATUS_STICKY_LSB + k]) begin
                    sticky_q[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            if (we_i) begin
                rdata_q <= '0;
                err_q   <= !(is_ch || is_status);
            end else if (is_ch) begin
                rdata_q <= rb_q[ch_idx];
                err_q   <= 1'b0;
            end else if (is_status) begin
                rdata_q <= status_val;
                err_q   <= 1'b0;
            end else begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end else if (done_hit) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign reg2ip_data_o = data_q;
    assign rvalid_o      = (state_q == RESP);
    assign rdata_o       = rvalid_o ? rdata_q : '0;
    assign err_o         = rvalid_o & err_q;

endmodule

// File: tb/tb_custom_ip_regif.sv
// Scoreboard bench for custom_ip_regif: host requests push expected responses
// and write pulses; a negedge monitor pops and compares them.
module tb_custom_ip_regif;

    localparam int NUM_CH = 3;
    localparam int DW     = 32;
    localparam int AW     = 12;
    localparam int TMO    = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 req_i, gnt_o, we_i;
    logic [AW-1:0]        addr_i;
    logic [DW/8-1:0]      be_i;
    logic [DW-1:0]        wdata_i;
    logic                 rvalid_o, err_o;
    logic [DW-1:0]        rdata_o;
    logic [NUM_CH*DW-1:0] reg2ip_data_o;
    logic [NUM_CH-1:0]    reg2ip_en_o;
    logic [NUM_CH-1:0]    done_i;
    logic [NUM_CH*DW-1:0] ip2reg_data_i;
    logic [NUM_CH-1:0]    ip2reg_en_i;

    custom_ip_regif #(.NUM_CH(NUM_CH), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
        .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .reg2ip_data_o(reg2ip_data_o), .reg2ip_en_o(reg2ip_en_o),
        .done_i(done_i), .ip2reg_data_i(ip2reg_data_i), .ip2reg_en_i(ip2reg_en_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [DW-1:0] rdata; logic err; } resp_t;
    typedef struct { int ch; logic [DW-1:0] data; } pulse_t;

    resp_t  sb_q[$];
    pulse_t pulse_q[$];
    int     n_vec = 0;
    int     n_err = 0;
    int     done_delay = -1;
    logic [NUM_CH-1:0] done_mask = '0;
    logic [DW-1:0] exp_shadow [NUM_CH];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                                  input logic [3:0] be);
        logic [DW-1:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    // One host transaction; lat = cycles from grant to rvalid.
    task automatic host(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] b, input logic [DW-1:0] er, input logic ee,
                        output int lat);
        int n;
        @(posedge clk_i); #1;
        req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d; be_i = b;
        sb_q.push_back('{rdata: er, err: ee});
        @(negedge clk_i);
        check("gnt_same_cycle", gnt_o, 1);
        n = 0;
        while (!gnt_o && n < 20) begin @(negedge clk_i); n++; end
        @(posedge clk_i); #1;
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
        lat = 0;
        do begin @(negedge clk_i); lat++; end while (!rvalid_o && lat < 50);
        if (!rvalid_o) check("rvalid_wait", 0, 1);
    endtask

    task automatic ch_write(input int ch, input logic [DW-1:0] d, input logic [3:0] b,
                            input logic ee, output int lat);
        exp_shadow[ch] = merge_bytes(exp_shadow[ch], d, b);
        pulse_q.push_back('{ch: ch, data: exp_shadow[ch]});
        host(1'b1, AW'(ch * 4), d, b, '0, ee, lat);
    endtask

    // Monitor: responses and write pulses against the scoreboard queues.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (rvalid_o) begin
                if (sb_q.size() == 0) check("unexp_rvalid", 1, 0);
                else begin
                    resp_t e;
                    e = sb_q.pop_front();
                    check("rdata", rdata_o, e.rdata);
                    check("err", err_o, e.err);
                end
            end else begin
                check("idle_resp", {rdata_o, err_o}, 0);
            end
            if (reg2ip_en_o != '0) begin
                if (pulse_q.size() == 0) check("unexp_en", reg2ip_en_o, 0);
                else begin
                    pulse_t p;
                    p = pulse_q.pop_front();
                    check("en_vec", reg2ip_en_o, 3'b001 << p.ch);
                    check("pulse_data", reg2ip_data_o[p.ch*DW +: DW], p.data);
                end
            end
        end
    end

    // IP model: answers a write pulse with done_mask after done_delay cycles (<0: never).
    initial begin
        done_i = '0;
        forever begin
            @(negedge clk_i);
            if (rst_ni && reg2ip_en_o != '0 && done_delay >= 0) begin
                if (done_delay > 0) begin repeat (done_delay) @(posedge clk_i); #1; end
                done_i = done_mask;
                @(posedge clk_i); #1;
                done_i = '0;
            end
        end
    end

    initial begin
        int lat;
        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
        ip2reg_data_i = '0; ip2reg_en_i = '0;
        for (int k = 0; k < NUM_CH; k++) exp_shadow[k] = '0;
        repeat (2) @(negedge clk_i);
        check("rst_outs", {gnt_o, rvalid_o, err_o, rdata_o, reg2ip_en_o}, 0);
        check("rst_data", reg2ip_data_o, 0);
        rst_ni = 1'b1;

        // Channel write, done three cycles after the pulse.
        done_delay = 3; done_mask = 3'b010;
        ch_write(1, 32'hDEADBEEF, 4'hF, 1'b0, lat);
        check("lat_wr_done3", lat, 5);
        host(1'b0, 12'h040, '0, '0, 32'h0, 1'b0, lat);
        check("lat_rd", lat, 1);

        // Byte-enable merge and minimum write latency.
        done_delay = 1; done_mask = 3'b001;
        ch_write(0, 32'h11223344, 4'hF, 1'b0, lat);
        check("lat_wr_min", lat, 3);
        ch_write(0, 32'hAABBCCDD, 4'b0101, 1'b0, lat);
        check("merge_hold", reg2ip_data_o[0 +: DW], 32'h11BB33DD);

        // Timeout with done only on other channels, then W1C.
        done_delay = 2; done_mask = 3'b011;
        ch_write(2, 32'h12345678, 4'hF, 1'b1, lat);
        check("lat_timeout", lat, TMO + 2);
        host(1'b0, 12'h040, '0, '0, 32'h4, 1'b0, lat);
        host(1'b1, 12'h040, 32'h4, 4'hF, 32'h0, 1'b0, lat);
        host(1'b0, 12'h040, '0, '0, 32'h0, 1'b0, lat);

        // done_i asserted only during PULSE is ignored.
        done_delay = 0; done_mask = 3'b010;
        ch_write(1, 32'h0000CAFE, 4'h3, 1'b1, lat);
        host(1'b0, 12'h040, '0, '0, 32'h2, 1'b0, lat);
        host(1'b1, 12'h040, 32'h0, 4'hF, 32'h0, 1'b0, lat);
        host(1'b0, 12'h040, '0, '0, 32'h2, 1'b0, lat);
        host(1'b1, 12'h040, 32'h2, 4'hF, 32'h0, 1'b0, lat);
        host(1'b0, 12'h040, '0, '0, 32'h0, 1'b0, lat);

        // Read-back capture, including capture coinciding with a host read.
        @(posedge clk_i); #1;
        ip2reg_data_i[0 +: DW] = 32'h5A5A0001; ip2reg_en_i = 3'b001;
        @(posedge clk_i); #1;
        ip2reg_en_i = '0;
        host(1'b0, 12'h000, '0, '0, 32'h5A5A0001, 1'b0, lat);
        fork
            host(1'b0, 12'h000, '0, '0, 32'h5A5A0001, 1'b0, lat);
            begin
                @(posedge clk_i); #1;
                ip2reg_data_i[0 +: DW] = 32'h2; ip2reg_en_i = 3'b001;
                @(posedge clk_i); #1;
                ip2reg_en_i = '0;
            end
        join
        host(1'b0, 12'h000, '0, '0, 32'h2, 1'b0, lat);
        done_delay = 1; done_mask = 3'b001;
        fork
            ch_write(0, 32'h01010101, 4'hF, 1'b0, lat);
            begin
                repeat (3) @(posedge clk_i); #1;
                ip2reg_data_i[DW +: DW] = 32'h77; ip2reg_en_i = 3'b010;
                @(posedge clk_i); #1;
                ip2reg_en_i = '0;
            end
        join
        host(1'b0, 12'h004, '0, '0, 32'h77, 1'b0, lat);

        // Unmapped and out-of-range accesses.
        host(1'b0, 12'h080, '0, '0, 32'h0, 1'b1, lat);
        host(1'b0, 12'h00C, '0, '0, 32'h0, 1'b1, lat);
        host(1'b1, 12'h00C, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, lat);
        check("lat_wr_unmapped", lat, 1);
        host(1'b1, 12'h080, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, lat);
        host(1'b0, 12'h002, '0, '0, 32'h0, 1'b1, lat);

        // Reset while waiting for done.
        done_delay = -1;
        @(posedge clk_i); #1;
        req_i = 1'b1; we_i = 1'b1; addr_i = 12'h000; wdata_i = 32'hCAFEF00D; be_i = 4'hF;
        pulse_q.push_back('{ch: 0, data: 32'hCAFEF00D});
        @(negedge clk_i);
        check("gnt_rst_wr", gnt_o, 1);
        @(posedge clk_i); #1;
        req_i = 1'b0; we_i = 1'b0; wdata_i = '0; be_i = '0;
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("abort_outs", {gnt_o, rvalid_o, err_o, rdata_o, reg2ip_en_o}, 0);
        check("abort_data", reg2ip_data_o, 0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < NUM_CH; k++) exp_shadow[k] = '0;
        host(1'b0, 12'h040, '0, '0, 32'h0, 1'b0, lat);
        host(1'b0, 12'h000, '0, '0, 32'h0, 1'b0, lat);
        done_delay = 1; done_mask = 3'b100;
        ch_write(2, 32'hFFFFFFFF, 4'b0011, 1'b0, lat);

        repeat (3) @(negedge clk_i);
        check("sb_drained", sb_q.size(), 0);
        check("pulses_drained", pulse_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "bench time limit reached");
    end

endmodule
